muldiv_hilo: RTL and testbench

Iterative multiply/divide unit that owns the HI/LO register pair, sitting beside the execute-stage ALU in the MIPS32 datapath. It takes the same A/B operands, runs MULT/MULTU/DIV/DIVU over multiple cycles, and writes the 64-bit result into HI/LO for MFHI/MFLO. It also handles MTHI/MTLO. Busy stalls the pipeline while an operation is in flight.

---
 rtl/muldiv_hilo.sv | 173 +++++++++++++++++
 tb/tb_muldiv_hilo.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO and also handles MTHI/MTLO.
// Latency: WIDTH+1 edges from the Start edge to the HI/LO write and the Done pulse.
// Backpressure: Busy stalls upstream, and Start is ignored while Busy is high.
// Optional MULDIV_FAST_MUL_EN: MULT/MULTU use a single-cycle multiplier and write at edge 1.
module muldiv_hilo #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_FAST} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div, neg_lo, neg_hi, div_zero;

    logic               idle_start, start_md, start_mul, signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_part, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] acc_step, prod_mag, prod_fix;
    logic [WIDTH-1:0]   hi_res, lo_res;

    assign idle_start = (state == S_IDLE) && Start && !Flush;
    assign start_mul  = idle_start && (Op == OP_MULT || Op == OP_MULTU);
    assign start_md   = start_mul || (idle_start && (Op == OP_DIV || Op == OP_DIVU));
    assign signed_op  = (Op == OP_MULT) || (Op == OP_DIV);
    assign a_neg      = signed_op && A[WIDTH-1];
    assign b_neg      = signed_op && B[WIDTH-1];
    assign a_mag      = a_neg ? -A : A;
    assign b_mag      = b_neg ? -B : B;
    assign Busy       = (state != S_IDLE);

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign div_part = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_part - {1'b0, opnd};
    assign div_ge   = (div_part >= {1'b0, opnd});

    always_comb begin
        acc_step = '0;
        if (is_div)
            acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        else
            acc_step = {mul_sum, acc[WIDTH-1:1]};
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, acc[WIDTH-1:0]} * {{WIDTH{1'b0}}, opnd};
    assign prod_mag  = (state == S_FAST) ? fast_prod : acc;
`else
    assign prod_mag  = acc;
`endif

    // A zero divisor keeps the all-ones quotient unnegated so that LO stays all ones for DIV too.
    always_comb begin
        hi_res   = '0;
        lo_res   = '0;
        prod_fix = neg_lo ? -prod_mag : prod_mag;
        if (is_div) begin
            lo_res = (neg_lo && !div_zero) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            hi_res = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end else begin
            lo_res = prod_fix[WIDTH-1:0];
            hi_res = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_md) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_nxt = start_mul ? S_FAST : S_RUN;
`else
                    state_nxt = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (Flush)
                    state_nxt = S_IDLE;
                else if (cnt == CNT_W'(WIDTH-1))
                    state_nxt = S_FIX;
            end
            S_FIX:   state_nxt = S_IDLE;
            S_FAST:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            HI       <= '0;
            LO       <= '0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_md) begin
                        cnt      <= '0;
                        is_div   <= !start_mul;
                        neg_lo   <= a_neg ^ b_neg;
                        neg_hi   <= a_neg;
                        div_zero <= (B == '0);
                        if (start_mul) begin
                            acc  <= {{WIDTH{1'b0}}, b_mag};
                            opnd <= a_mag;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, a_mag};
                            opnd <= b_mag;
                        end
                    end else if (idle_start && Op == OP_MTHI) begin
                        HI <= A;
                    end else if (idle_start && Op == OP_MTLO) begin
                        LO <= A;
                    end
                end
                S_RUN: begin
                    if (!Flush) begin
                        acc <= acc_step;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_FIX, S_FAST: begin
                    if (!Flush) begin
                        HI   <= hi_res;
                        LO   <= lo_res;
                        Done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed bench for muldiv_hilo (default build, iterative multiply).
module tb_muldiv_hilo;
    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic        Clock, Reset_n, Start, Flush, Busy, Done;
    logic [2:0]  Op;
    logic [31:0] A, B, HI, LO;
    int          checks = 0;
    int          errors = 0;
    int          busy_cnt, done_cnt;

    muldiv_hilo #(.WIDTH(32), .CNT_W(6)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Op(Op), .A(A), .B(B),
        .Flush(Flush), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive Start for one edge (edge 0); returns at the negedge after edge 0.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; Op = op; A = a; B = b;
        @(negedge Clock);
        Start = 1'b0; Op = OP_NOP;
    endtask

    // Full mult/div operation; returns in the Done cycle (after edge 33).
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(op, a, b);
        busy_cnt = 0; done_cnt = 0;
        repeat (33) begin
            if (Busy) busy_cnt++;
            if (Done) done_cnt++;
            @(negedge Clock);
        end
        check({tag, " busy_cycles"}, busy_cnt, 33);
        check({tag, " early_done"}, done_cnt, 0);
        check({tag, " busy_end"}, {31'b0, Busy}, 0);
        check({tag, " done"}, {31'b0, Done}, 1);
        check({tag, " hi"}, HI, exp_hi);
        check({tag, " lo"}, LO, exp_lo);
    endtask

    initial begin
        Reset_n = 1'b0; Start = 1'b0; Flush = 1'b0; Op = OP_NOP; A = '0; B = '0;
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        check("reset hi", HI, 32'h0);
        check("reset lo", LO, 32'h0);
        check("reset busy", {31'b0, Busy}, 0);
        check("reset done", {31'b0, Done}, 0);

        do_op("mult_neg3x5", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        @(negedge Clock);
        check("done_one_cycle", {31'b0, Done}, 0);
        do_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        // Next ops are issued in the Done cycle of the previous one.
        do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        do_op("div_neg7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("div_7_neg2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        do_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        do_op("divu_by0", OP_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF);
        do_op("div_neg_by0", OP_DIV, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFF);
        @(negedge Clock);

        issue(OP_MTHI, 32'hDEADBEEF, 32'h0);
        check("mthi hi", HI, 32'hDEADBEEF);
        check("mthi lo_kept", LO, 32'hFFFFFFFF);
        check("mthi busy", {31'b0, Busy}, 0);
        check("mthi done", {31'b0, Done}, 0);
        issue(OP_MTLO, 32'h0BADF00D, 32'h0);
        check("mtlo lo", LO, 32'h0BADF00D);
        check("mtlo hi_kept", HI, 32'hDEADBEEF);

        // Start of MULTU at edge 10 of a DIVU must be ignored.
        issue(OP_DIVU, 32'd1000, 32'd9);
        repeat (9) @(negedge Clock);
        Start = 1'b1; Op = OP_MULTU; A = 32'd3; B = 32'd4;
        @(negedge Clock);
        Start = 1'b0; Op = OP_NOP;
        repeat (23) @(negedge Clock);
        check("ign done", {31'b0, Done}, 1);
        check("ign hi", HI, 32'd1);
        check("ign lo", LO, 32'd111);
        @(negedge Clock);
        check("ign no_followup", {31'b0, Busy}, 0);

        // Flush at edge 12 of MULTU.
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (11) @(negedge Clock);
        Flush = 1'b1;
        @(negedge Clock);
        Flush = 1'b0;
        check("flush busy", {31'b0, Busy}, 0);
        done_cnt = 0;
        repeat (25) begin
            if (Done) done_cnt++;
            @(negedge Clock);
        end
        check("flush no_done", done_cnt, 0);
        check("flush hi", HI, 32'd1);
        check("flush lo", LO, 32'd111);

        // Flush beats Start in IDLE.
        Flush = 1'b1;
        issue(OP_MTHI, 32'h55555555, 32'h0);
        check("flush_start mthi", HI, 32'd1);
        issue(OP_DIVU, 32'd50, 32'd5);
        Flush = 1'b0;
        check("flush_start busy", {31'b0, Busy}, 0);

        // Asynchronous reset in the middle of a DIV.
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (4) @(negedge Clock);
        #2 Reset_n = 1'b0;
        #1;
        check("arst hi", HI, 32'h0);
        check("arst lo", LO, 32'h0);
        check("arst busy", {31'b0, Busy}, 0);
        @(negedge Clock);
        Reset_n = 1'b1;
        do_op("mult_after_rst", OP_MULT, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6);
        @(negedge Clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
